// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive buffer downstream of the UART receiver. Each receiver pulse
//   (rx_valid_i or rx_frame_err_i) pushes {err, data} into a flop-based FIFO.
//   The FIFO has a first-word-fall-through pop port and provides count,
//   sticky overrun, fill-threshold and idle-timeout status.
//
// Ports
//   clk, rst_n      clock; synchronous active-low reset
//   rx_data_i       received character, qualified by the pulses below
//   rx_valid_i      good-character pulse
//   rx_frame_err_i  bad-stop-bit pulse (entry tagged err = 1)
//   rd_en_i         pop head entry (ignored when empty)
//   flush_i         discard all entries (highest priority)
//   ovr_clr_i       clear sticky overrun flag
//   thresh_i        fill threshold, 0 disables
//   timeout_lim_i   idle cycles before timeout, 0 disables
//   rd_data_o       head data (valid when !empty_o)
//   rd_err_o        head framing-error tag
//   empty_o/full_o  occupancy flags from the registered count
//   count_o         occupied entries 0..DEPTH
//   overrun_o       sticky: a push was dropped while full
//   thresh_irq_o    count_o >= thresh_i (thresh_i != 0)
//   timeout_o       non-empty and idle for timeout_lim_i cycles
module uart_rx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned TO_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        rx_data_i,
    input  logic                     rx_valid_i,
    input  logic                     rx_frame_err_i,
    input  logic                     rd_en_i,
    input  logic                     flush_i,
    input  logic                     ovr_clr_i,
    input  logic [$clog2(DEPTH):0]   thresh_i,
    input  logic [TO_W-1:0]          timeout_lim_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     rd_err_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overrun_o,
    output logic                     thresh_irq_o,
    output logic                     timeout_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_W:0] mem_q [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovr_q, ovr_d;
    logic [TO_W-1:0] idle_q, idle_d;

    logic push, empty, full, pop_ok, push_ok, ovr_set;

    always_comb begin
        push    = rx_valid_i | rx_frame_err_i;
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        pop_ok  = rd_en_i & ~empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok = push & (~full | pop_ok);
        // A push discarded by flush is not an overrun.
        ovr_set = push & full & ~pop_ok & ~flush_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-2 depth: pointers wrap naturally.
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (ovr_clr_i) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_comb begin
        if (flush_i || push || pop_ok || empty) begin
            idle_d = '0;
        end else if (idle_q != '1) begin
            idle_d = idle_q + 1'b1;
        end else begin
            idle_d = idle_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            idle_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            idle_q   <= idle_d;
        end
    end

    // Storage is not reset; the reset pointers make old contents unreachable.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= {rx_frame_err_i, rx_data_i};
        end
    end

    always_comb begin
        rd_data_o    = mem_q[rd_ptr_q][DATA_W-1:0];
        rd_err_o     = mem_q[rd_ptr_q][DATA_W];
        empty_o      = empty;
        full_o       = full;
        count_o      = count_q;
        overrun_o    = ovr_q;
        thresh_irq_o = (thresh_i != '0) && (count_q >= thresh_i);
        timeout_o    = !empty && (timeout_lim_i != '0) && (idle_q >= timeout_lim_i);
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int TO_W   = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] rx_data_i;
    logic              rx_valid_i, rx_frame_err_i, rd_en_i, flush_i, ovr_clr_i;
    logic [CW-1:0]     thresh_i;
    logic [TO_W-1:0]   timeout_lim_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_err_o, empty_o, full_o, overrun_o, thresh_irq_o, timeout_o;
    logic [CW-1:0]     count_o;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of {err, data}, overrun flag, cycles since activity.
    logic [DATA_W:0] mq[$];
    bit              m_ovr;
    int              m_idle;

    uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TO_W(TO_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data_i      (rx_data_i),
        .rx_valid_i     (rx_valid_i),
        .rx_frame_err_i (rx_frame_err_i),
        .rd_en_i        (rd_en_i),
        .flush_i        (flush_i),
        .ovr_clr_i      (ovr_clr_i),
        .thresh_i       (thresh_i),
        .timeout_lim_i  (timeout_lim_i),
        .rd_data_o      (rd_data_o),
        .rd_err_o       (rd_err_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .count_o        (count_o),
        .overrun_o      (overrun_o),
        .thresh_irq_o   (thresh_irq_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit push, pop, was_empty, full, set;
        if (!rst_n) begin
            mq.delete();
            m_ovr  = 0;
            m_idle = 0;
            return;
        end
        push      = rx_valid_i || rx_frame_err_i;
        was_empty = (mq.size() == 0);
        full      = (mq.size() == DEPTH);
        pop       = rd_en_i && !was_empty;
        set       = !flush_i && push && full && !pop;
        if (flush_i) begin
            mq.delete();
            m_idle = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push && !(full && !pop)) mq.push_back({rx_frame_err_i, rx_data_i});
            if (push || pop || was_empty) m_idle = 0;
            else if (m_idle < (1 << TO_W) - 1) m_idle++;
        end
        if (set) m_ovr = 1;
        else if (ovr_clr_i) m_ovr = 0;
    endtask

    task automatic model_check();
        int n;
        n = mq.size();
        chk("count", count_o, n);
        chk("empty", empty_o, n == 0);
        chk("full", full_o, n == DEPTH);
        chk("overrun", overrun_o, m_ovr);
        chk("thresh_irq", thresh_irq_o, (thresh_i != 0) && (n >= thresh_i));
        chk("timeout", timeout_o, (n > 0) && (timeout_lim_i != 0) && (m_idle >= timeout_lim_i));
        if (n > 0) begin
            chk("rd_data", rd_data_o, mq[0][DATA_W-1:0]);
            chk("rd_err", rd_err_o, mq[0][DATA_W]);
        end
    endtask

    // One clock: inputs already driven; model follows the edge, outputs checked at +1.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        model_check();
    endtask

    task automatic clr_inputs();
        rx_valid_i     = 0;
        rx_frame_err_i = 0;
        rd_en_i        = 0;
        flush_i        = 0;
        ovr_clr_i      = 0;
    endtask

    task automatic push(input logic [7:0] d, input bit err);
        rx_data_i = d;
        rx_valid_i = !err;
        rx_frame_err_i = err;
        step();
        clr_inputs();
    endtask

    task automatic pop();
        rd_en_i = 1;
        step();
        clr_inputs();
    endtask

    task automatic idle();
        step();
    endtask

    typedef struct {
        logic       vld;
        logic       ferr;
        logic [7:0] data;
        logic       rd;
        logic       chk_data;
        logic [4:0] cnt;
        logic       emp;
        logic       ful;
        logic [7:0] exp_d;
        logic       exp_e;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 8'hA5, 1'b0};
        vt[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0};
        vt[2] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 8'h3C, 1'b1};
        vt[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0};
        vt[4] = '{1'b1, 1'b1, 8'h81, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 8'h81, 1'b1};
        vt[5] = '{1'b1, 1'b0, 8'h42, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 8'h42, 1'b0};
        vt[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0};
        vt[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0};
        vt[8] = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 8'h11, 1'b0};
        vt[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0};

        rst_n = 0;
        rx_data_i = '0;
        thresh_i = '0;
        timeout_lim_i = '0;
        clr_inputs();
        step();
        step();
        chk("reset_count", count_o, 0);
        chk("reset_empty", empty_o, 1);
        chk("reset_overrun", overrun_o, 0);
        rst_n = 1;
        step();

        // Directed table
        foreach (vt[i]) begin
            rx_valid_i = vt[i].vld;
            rx_frame_err_i = vt[i].ferr;
            rx_data_i = vt[i].data;
            rd_en_i = vt[i].rd;
            step();
            clr_inputs();
            chk($sformatf("vec%0d_count", i), count_o, vt[i].cnt);
            chk($sformatf("vec%0d_empty", i), empty_o, vt[i].emp);
            chk($sformatf("vec%0d_full", i), full_o, vt[i].ful);
            if (vt[i].chk_data) begin
                chk($sformatf("vec%0d_data", i), rd_data_o, vt[i].exp_d);
                chk($sformatf("vec%0d_err", i), rd_err_o, vt[i].exp_e);
            end
        end

        // Fill, overrun, drain in order, clear overrun
        for (int i = 0; i < DEPTH; i++) push(8'(i), 0);
        chk("fill_full", full_o, 1);
        chk("fill_count", count_o, 16);
        push(8'h55, 0);
        chk("ovr_set", overrun_o, 1);
        chk("ovr_count", count_o, 16);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_data", rd_data_o, i);
            pop();
        end
        chk("drain_empty", empty_o, 1);
        chk("ovr_sticky", overrun_o, 1);
        ovr_clr_i = 1;
        step();
        clr_inputs();
        chk("ovr_clr", overrun_o, 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) push(8'(8'h20 + i), 0);
        rx_data_i = 8'h77;
        rx_valid_i = 1;
        rd_en_i = 1;
        step();
        clr_inputs();
        chk("fullpp_ovr", overrun_o, 0);
        chk("fullpp_count", count_o, 16);
        chk("fullpp_head", rd_data_o, 8'h21);
        for (int i = 0; i < DEPTH - 1; i++) pop();
        chk("fullpp_tail", rd_data_o, 8'h77);
        pop();
        // Pointer wrap under streaming push/pop
        push(8'hE0, 0);
        for (int i = 0; i < 20; i++) begin
            rx_data_i = 8'(8'hC0 + i);
            rx_valid_i = 1;
            rd_en_i = 1;
            step();
            clr_inputs();
        end
        chk("wrap_head", rd_data_o, 8'hD3);
        pop();

        // Threshold
        thresh_i = 4;
        for (int i = 0; i < 3; i++) push(8'(i), 0);
        chk("thr_below", thresh_irq_o, 0);
        push(8'h03, 0);
        chk("thr_reach", thresh_irq_o, 1);
        pop();
        chk("thr_pop", thresh_irq_o, 0);
        thresh_i = 0;
        push(8'h09, 0);
        chk("thr_disabled", thresh_irq_o, 0);
        flush_i = 1;
        step();
        clr_inputs();

        // Timeout
        timeout_lim_i = 10;
        push(8'h66, 0);
        for (int i = 0; i < 9; i++) idle();
        chk("to_early", timeout_o, 0);
        idle();
        chk("to_fire", timeout_o, 1);
        pop();
        chk("to_pop", timeout_o, 0);
        chk("to_empty", empty_o, 1);
        timeout_lim_i = 0;

        // Flush with same-cycle push
        for (int i = 0; i < 5; i++) push(8'(i), 0);
        flush_i = 1;
        rx_valid_i = 1;
        rx_data_i = 8'h99;
        step();
        clr_inputs();
        chk("flush_count", count_o, 0);
        chk("flush_empty", empty_o, 1);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) push(8'(i), 1);
        rst_n = 0;
        step();
        rst_n = 1;
        chk("midrst_count", count_o, 0);
        chk("midrst_empty", empty_o, 1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                thresh_i = CW'($urandom_range(0, 20));
                timeout_lim_i = TO_W'($urandom_range(0, 6));
            end
            rx_data_i = 8'($urandom);
            rx_valid_i = ($urandom_range(0, 99) < 45);
            rx_frame_err_i = ($urandom_range(0, 99) < 10);
            rd_en_i = ($urandom_range(0, 99) < (c % 600 < 300 ? 25 : 60));
            flush_i = ($urandom_range(0, 99) < 2);
            ovr_clr_i = ($urandom_range(0, 99) < 5);
            rst_n = ($urandom_range(0, 999) >= 3);
            step();
            clr_inputs();
            rst_n = 1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
